// File: rtl/pipelined_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// stage limits, the chunk-width helper, the full-adder cell and the
// per-stage control record.
package pipelined_rca_pkg;

  // Upper bound on pipeline depth accepted at elaboration
  localparam int MAX_STAGES = 64;

  // Width of one ripple chunk
  function automatic int chunk_width(input int n, input int stages);
    return n / stages;
  endfunction

  // One-bit full-adder cell, returned as {carry, sum}
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Control part of a stage record; the width-dependent data part
  // (partial sum, skewed operands) lives in the top where N is known
  typedef struct packed {
    logic vld;
    logic carry;
    logic sub;
  } stage_ctl_t;

endpackage

// File: rtl/rca_chunk.sv
// W-bit combinational ripple-carry chunk built from the package full-adder
// cell. c_msb_in exposes the carry into the top bit so the last chunk can
// derive two's-complement overflow.
module rca_chunk
  import pipelined_rca_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {w_c[i+1], sum[i]} = full_add(a[i], b[i], w_c[i]);
  end

  assign cout     = w_c[W];
  assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor. The N-bit datapath is cut into
// STAGES equal chunks, one register stage each; upper operand bits ride
// along in skew registers until their chunk is reached, finished low sum
// bits ride along to the output. All stages advance together whenever the
// output slot is empty or being drained.
// Optional feature: define PIPE_RCA_OVF_EN to add the registered
// two's-complement overflow output.
module pipelined_rca_addsub
  import pipelined_rca_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic         overflow
`endif
);

  localparam int W = chunk_width(N, STAGES);

  if ((STAGES < 1) || (STAGES > N) || (STAGES > MAX_STAGES) || ((N % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_rca_addsub: N must be a multiple of STAGES and 1 <= STAGES <= N");
  end

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
  } stage_dat_t;

  stage_ctl_t          r_ctl_p [STAGES];
  stage_dat_t          r_dat_p [STAGES];
  logic [STAGES-1:0]   w_cout;
  logic [STAGES-1:0]   w_cmsb;
  logic [STAGES-1:0]   w_unused_bits;
  logic                w_unused;
  logic                w_adv;
  logic [N-1:0]        w_b_in;
  logic                w_c_in;

  // The whole pipe moves only when the output slot can take a new entry
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1; carry_in is ignored in that mode
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub | carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_ctl_t  w_src_ctl;
    stage_dat_t  w_src_dat;
    stage_dat_t  w_nxt_dat;
    logic [W-1:0] w_csum;

    if (k == 0) begin : g_head
      assign w_src_ctl = '{vld: in_valid, carry: w_c_in, sub: sub};
      assign w_src_dat = '{a: a, b: w_b_in, s: {N{1'b0}}};
    end else begin : g_body
      assign w_src_ctl = r_ctl_p[k-1];
      assign w_src_dat = r_dat_p[k-1];
    end

    rca_chunk #(.W(W)) u_chunk (
      .a        (w_src_dat.a[k*W +: W]),
      .b        (w_src_dat.b[k*W +: W]),
      .cin      (w_src_ctl.carry),
      .sum      (w_csum),
      .cout     (w_cout[k]),
      .c_msb_in (w_cmsb[k])
    );

    // Splice this chunk's sum bits into the travelling partial sum
    always_comb begin
      w_nxt_dat = w_src_dat;
      w_nxt_dat.s[k*W +: W] = w_csum;
    end

    // ---- stage k control register: valid, chunk carry-out, mode ----
    always_ff @(posedge clk) begin
      if (rst) begin
        r_ctl_p[k] <= '0;
      end else if (w_adv) begin
        r_ctl_p[k] <= '{vld: w_src_ctl.vld, carry: w_cout[k], sub: w_src_ctl.sub};
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // ---- output stage data register: cleared so sum reads 0 after reset ----
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dat_p[k] <= '0;
        end else if (w_adv) begin
          r_dat_p[k] <= w_nxt_dat;
        end
      end
    end else begin : g_mid
      // ---- stage k data register: skewed operands and partial sum ----
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_dat_p[k] <= w_nxt_dat;
        end
      end
    end

    // Already-consumed operand bits, the mode flag and unneeded MSB carries
    assign w_unused_bits[k] = ^{r_dat_p[k].a, r_dat_p[k].b, r_ctl_p[k].sub, w_cmsb[k]};
  end

  assign w_unused = ^w_unused_bits;

  assign out_valid = r_ctl_p[STAGES-1].vld;
  assign carry_out = r_ctl_p[STAGES-1].carry;
  assign sum       = r_dat_p[STAGES-1].s;

`ifdef PIPE_RCA_OVF_EN
  logic r_ovf_p;

  // ---- overflow register, aligned with the output stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_p <= 1'b0;
    end else if (w_adv) begin
      r_ovf_p <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
    end
  end

  assign overflow = r_ovf_p;
`endif

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Directed bench for pipelined_rca_addsub (N=8, STAGES=2) plus a short
// randomised run of an N=16, STAGES=4 instance against a behavioural model.
// Define PIPE_RCA_OVF_EN to include the overflow port and its checks.
module tb_pipelined_rca_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out;
  logic [7:0]  a, b, sum;
  logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, carry_out16;
  logic [15:0] a16, b16, sum16;
`ifdef PIPE_RCA_OVF_EN
  logic        overflow, overflow16;
`endif

  int checks = 0;
  int errors = 0;
  logic [17:0] q[$];

  pipelined_rca_addsub #(.N(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out)
`ifdef PIPE_RCA_OVF_EN
    , .overflow(overflow)
`endif
  );

  pipelined_rca_addsub #(.N(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .carry_in(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .carry_out(carry_out16)
`ifdef PIPE_RCA_OVF_EN
    , .overflow(overflow16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tc, input logic ts);
    in_valid = v;
    a        = ta;
    b        = tb_v;
    carry_in = tc;
    sub      = ts;
  endtask

  // One isolated transaction: latency 2, then a bubble
  task automatic single(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ts, input logic [7:0] es,
                        input logic ec, input logic eo);
    drive(1'b1, ta, tb_v, tc, ts);
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, {23'd0, carry_out, sum}, {23'd0, ec, es});
`ifdef PIPE_RCA_OVF_EN
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
`endif
    step();
    chk({tag, "_bub"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [7:0]  vs [4];
    logic [16:0] t;
    logic [15:0] bb;
    logic [31:0] exp32;

    va = '{8'h10, 8'h20, 8'h30, 8'h40};
    vb = '{8'h01, 8'h02, 8'h03, 8'h04};
    vs = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    out_ready   = 1'b1;
    in_valid16  = 1'b0;
    a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0; sub16 = 1'b0;
    out_ready16 = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", {23'd0, carry_out, sum}, 32'd0);
`ifdef PIPE_RCA_OVF_EN
    chk("rst_ovf", 32'(overflow), 32'd0);
`endif
    chk("rst_vld16", 32'(out_valid16), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_rdy", 32'(in_ready), 32'd1);

    // Isolated transactions
    single("wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    single("sub_bw", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    single("sub_ok", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    single("cin",    8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0);
    single("sub_ci", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
    single("xchunk", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
`ifdef PIPE_RCA_OVF_EN
    single("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    single("ovf_sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    single("ovf_no",  8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

    // Back-to-back stream, results on consecutive cycles
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, va[i], vb[i], 1'b0, 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      #1;
      chk($sformatf("b2b_rdy%0d", i), 32'(in_ready), 32'd1);
      if (i >= 2 && i < 6) begin
        chk($sformatf("b2b_vld%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("b2b_sum%0d", i), 32'(sum), 32'(vs[i-2]));
      end
      if (i == 6) chk("b2b_end", 32'(out_valid), 32'd0);
      step();
    end

    // Backpressure with a full pipe, then drain with overlapping handshakes
    drive(1'b1, 8'h55, 8'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_sum%0d", i), 32'(sum), 32'h66);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    chk("bp_rel_sum", 32'(sum), 32'h66);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    chk("bp_d1_vld", 32'(out_valid), 32'd1);
    chk("bp_d1_sum", 32'(sum), 32'h46);
    step();
    chk("bp_d2_vld", 32'(out_valid), 32'd1);
    chk("bp_d2_sum", 32'(sum), 32'h02);
    step();
    chk("bp_d3_vld", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight
    drive(1'b1, 8'hA1, 8'h01, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hB1, 8'h01, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("fl_vld0", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("fl_vld1", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    step();
    chk("fl_vld2", 32'(out_valid), 32'd0);
    single("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // N=16 STAGES=4: random traffic and backpressure against a model
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc < 280) begin
        in_valid16  = ($urandom_range(0, 3) != 0);
        a16         = 16'($urandom);
        b16         = 16'($urandom);
        cin16       = 1'($urandom_range(0, 1));
        sub16       = 1'($urandom_range(0, 1));
        out_ready16 = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
      end
      #1;
      if (out_valid16 && out_ready16) begin
        exp32 = (q.size() > 0) ? {14'd0, q.pop_front()} : 32'hDEADBEEF;
`ifdef PIPE_RCA_OVF_EN
        chk($sformatf("r16_c%0d", cyc), {14'd0, overflow16, carry_out16, sum16}, exp32);
`else
        chk($sformatf("r16_c%0d", cyc), {15'd0, carry_out16, sum16}, {15'd0, exp32[16:0]});
`endif
      end
      if (in_valid16 && in_ready16) begin
        bb = sub16 ? ~b16 : b16;
        t  = {1'b0, a16} + {1'b0, bb} + {16'd0, (sub16 | cin16)};
        q.push_back({(a16[15] == bb[15]) && (t[15] != a16[15]), t});
      end
      step();
    end
    chk("r16_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
